// File: rtl/ram_port_master.sv
// ram_port_master: valid/ready initiator for one block RAM port.
// Read data is captured once and returned in order via a credit FIFO.
module ram_port_master #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic                  busy
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OW = PW + 1;

  logic [PW-1:0]         head_q, head_d;
  logic [PW-1:0]         tail_q, tail_d;
  logic [OW-1:0]         occ_q, occ_d;
  logic                  rd_pend_q, rd_pend_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic                  accept;
  logic                  push;
  logic                  pop;
  logic [OW:0]           credit_used;

  // Credit check uses registered state only, so no rsp_ready -> req_ready path.
  always_comb begin
    credit_used = {1'b0, occ_q} + (OW+1)'(rd_pend_q);
    req_ready   = !rst && (credit_used < (OW+1)'(FIFO_DEPTH));
  end

  // Raw RAM port drive; the address follows the request even when idle.
  always_comb begin
    accept   = req_valid && req_ready;
    ram_addr = req_addr;
    ram_din  = req_wdata;
    ram_we   = accept && req_we;
  end

  // Response side: head of FIFO, zeroed when empty.
  always_comb begin
    rsp_valid = (occ_q != '0);
    rsp_rdata = rsp_valid ? mem_q[head_q] : '0;
    busy      = rd_pend_q || rsp_valid;
  end

  // Next-state for pointers, occupancy and the in-flight flag.
  always_comb begin
    push      = rd_pend_q;
    pop       = rsp_valid && rsp_ready;
    rd_pend_d = accept && !req_we;
    head_d    = head_q;
    tail_d    = tail_q;
    occ_d     = occ_q + OW'(push) - OW'(pop);
    if (push) tail_d = tail_q + PW'(1);
    if (pop)  head_d = head_q + PW'(1);
  end

  // Control state register with synchronous flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q    <= '0;
      tail_q    <= '0;
      occ_q     <= '0;
      rd_pend_q <= 1'b0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      occ_q     <= occ_d;
      rd_pend_q <= rd_pend_d;
    end
  end

  // Capture RAM data on the single cycle it is valid.
  always_ff @(posedge clk) begin
    if (push && !rst) mem_q[tail_q] <= ram_dout;
  end

endmodule

// File: tb/tb_ram_port_master.sv
// tb_ram_port_master: random and directed traffic against a
// transaction-level model of the port (memory array + response queue).
module tb_ram_port_master;

  localparam int DW = 128;
  localparam int AW = 12;
  localparam int DEPTH = 4;

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;
  logic          busy;

  ram_port_master #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .ram_addr (ram_addr),
    .ram_we   (ram_we),
    .ram_din  (ram_din),
    .ram_dout (ram_dout),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write-first RAM port with registered read data.
  logic [DW-1:0] ram_mem [1<<AW];
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_din;
    if (rst) ram_dout <= '0;
    else ram_dout <= ram_we ? ram_din : ram_mem[ram_addr];
  end

  int nchk = 0;
  int nerr = 0;
  int cyc = 0;
  bit chk_en = 0;

  logic [DW-1:0] ref_mem [64];
  logic [DW-1:0] exp_q [$];
  int            acc_q [$];

  task automatic chk(input string tag, input logic [DW-1:0] got,
                     input logic [DW-1:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s cyc=%0d: got %h want %h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One clock cycle: apply inputs, check outputs, advance the model.
  task automatic step(input logic v, input logic we, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic rr, input logic r);
    logic exp_rv;
    logic exp_rdy;
    logic acc;
    @(negedge clk);
    req_valid = v;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    rsp_ready = rr;
    rst       = r;
    #1;
    exp_rv  = (exp_q.size() > 0) && (acc_q[0] + 2 <= cyc);
    exp_rdy = !r && (exp_q.size() < DEPTH);
    acc     = v && exp_rdy;
    if (chk_en) begin
      chk("req_ready", DW'(req_ready), DW'(exp_rdy));
      chk("rsp_valid", DW'(rsp_valid), DW'(exp_rv));
      chk("busy", DW'(busy), DW'(exp_q.size() > 0));
      chk("ram_we", DW'(ram_we), DW'(acc && we));
      chk("ram_addr", DW'(ram_addr), DW'(a));
      chk("ram_din", ram_din, d);
      if (exp_rv) chk("rsp_rdata", rsp_rdata, exp_q[0]);
      else chk("rdata_idle", rsp_rdata, '0);
    end
    if (exp_rv && rr && !r) begin
      void'(exp_q.pop_front());
      void'(acc_q.pop_front());
    end
    if (acc) begin
      if (we) ref_mem[a[5:0]] = d;
      else begin
        exp_q.push_back(ref_mem[a[5:0]]);
        acc_q.push_back(cyc);
      end
    end
    if (r) begin
      exp_q.delete();
      acc_q.delete();
    end
    cyc++;
  endtask

  task automatic idle(input int n, input logic rr);
    for (int i = 0; i < n; i++) step(0, 0, '0, '0, rr, 0);
  endtask

  initial begin
    logic [DW-1:0] a5;
    a5 = {(DW/8){8'hA5}};
    // Power-up reset; registers are unknown in the first cycle.
    step(0, 0, '0, '0, 0, 1);
    chk_en = 1;
    step(0, 0, '0, '0, 0, 1);
    // Preload addresses 0..63 through the port.
    for (int i = 0; i < 64; i++) step(1, 1, AW'(i), rnd128(), 0, 0);
    // Writes presented during reset must not reach the RAM.
    for (int i = 0; i < 3; i++) step(1, 1, 12'h020, rnd128(), 0, 1);
    step(1, 0, 12'h020, '0, 1, 0);
    idle(4, 1);
    // Write then read the same address on consecutive cycles.
    step(1, 1, 12'h010, a5, 1, 0);
    step(1, 0, 12'h010, '0, 1, 0);
    idle(5, 1);
    // Streaming reads with the client always ready.
    for (int i = 0; i < 16; i++) step(1, 0, AW'(i), '0, 1, 0);
    idle(5, 1);
    // Backpressure: only DEPTH reads get in, one pop frees one credit.
    for (int i = 0; i < 8; i++) step(1, 0, AW'(32 + i), '0, 0, 0);
    step(1, 0, AW'(40), '0, 1, 0);
    for (int i = 0; i < 4; i++) step(1, 0, AW'(41 + i), '0, 0, 0);
    idle(8, 1);
    // Hold occupancy near 3 with push and pop together; pointers wrap.
    for (int i = 0; i < 3; i++) step(1, 0, AW'(i + 5), '0, 0, 0);
    idle(1, 0);
    for (int i = 0; i < 9; i++) step(1, 0, AW'(48 + i), '0, 1, 0);
    idle(6, 1);
    // Reset with two queued responses and one in flight.
    step(1, 0, AW'(3), '0, 0, 0);
    step(1, 0, AW'(4), '0, 0, 0);
    step(1, 0, AW'(5), '0, 0, 0);
    step(0, 0, '0, '0, 0, 1);
    idle(2, 1);
    step(1, 0, AW'(9), '0, 1, 0);
    idle(4, 1);
    // Random mixed traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(3) != 0), ($urandom_range(3) == 0),
           AW'($urandom_range(15)), rnd128(),
           ($urandom_range(2) != 0), ($urandom_range(79) == 0));
    end
    idle(10, 1);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
